// File: rtl/spi_out_sched.sv
// spi_out_sched
// Round-robin scheduler sharing one output-only SPI master between NREQ
// requesters. A granted word is captured into a holding register that
// stays stable for the whole frame. The frame is tracked through the
// master's chip-select, and a minimum idle gap is kept between frames.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   req        per-requester request level, held until ack
//   req_data   word of requester i at [i*BITS +: BITS]
//   ack        one-cycle pulse: word captured, requester may move on
//   done       one-cycle pulse when the granted frame has completed
//   spi_cs     chip-select from the SPI master (low = frame active)
//   spi_start  start request to the SPI master
//   spi_data   holding register feeding the master's input buffer
//   busy       high in every state except IDLE
//   grant_id   index of the current or most recent grant
module spi_out_sched #(
  parameter int BITS = 8,
  parameter int NREQ = 2,
  parameter int GAP  = 2,
  localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BITS-1:0] req_data,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  input  logic                 spi_cs,
  output logic                 spi_start,
  output logic [BITS-1:0]      spi_data,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_HIGH,
    S_GAP
  } state_t;

  state_t          state_reg;
  logic [7:0]      gap_cnt_reg;

  logic [BITS-1:0] slice [NREQ];
  logic            win_found;
  logic [GW-1:0]   win_idx;
  int              idx;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = req_data[gi*BITS +: BITS];
    end
  endgenerate

  // Rotating priority: search from grant_id+1 upwards, wrapping. The loop
  // runs from the farthest offset to the nearest so the nearest set bit is
  // the last assignment and therefore wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(grant_id) + k) % NREQ;
      if (req[idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      gap_cnt_reg <= '0;
      ack         <= '0;
      done        <= '0;
      spi_start   <= 1'b0;
      spi_data    <= '0;
      busy        <= 1'b0;
      grant_id    <= GW'(NREQ - 1);
    end else begin
      ack  <= '0;
      done <= '0;
      case (state_reg)
        S_IDLE: begin
          // A low cs here belongs to a foreign or stale frame; wait it out.
          if (win_found && spi_cs) begin
            spi_data     <= slice[win_idx];
            grant_id     <= win_idx;
            ack[win_idx] <= 1'b1;
            spi_start    <= 1'b1;
            busy         <= 1'b1;
            state_reg    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (!spi_cs) begin
            spi_start <= 1'b0;
            state_reg <= S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          if (spi_cs) begin
            done[grant_id] <= 1'b1;
            if (GAP == 0) begin
              busy      <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              gap_cnt_reg <= 8'(GAP);
              state_reg   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          // Leaving at a count of 1 plus the IDLE grant cycle yields GAP+1
          // cycles from the done cycle to the next spi_start.
          if (gap_cnt_reg != 8'd0) begin
            gap_cnt_reg <= gap_cnt_reg - 8'd1;
          end
          if (gap_cnt_reg <= 8'd1) begin
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_out_sched.sv
module tb_spi_out_sched;

  typedef struct {
    int id;
    int word;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  // instance 0: GAP = 3, main scoreboard
  logic [1:0]  req0 = '0;
  logic [15:0] data0 = '0;
  logic [1:0]  ack0, done0;
  logic        cs0, start0, busy0;
  logic [7:0]  sdata0;
  logic [0:0]  gid0;

  // instance 1: GAP = 0, spacing check only
  logic [1:0]  req1 = '0;
  logic [15:0] data1 = 16'h0096;
  logic [1:0]  ack1, done1;
  logic        cs1, start1, busy1;
  logic [7:0]  sdata1;
  logic [0:0]  gid1;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t ack_q[$];
  exp_t frm_q[$];

  always #5 clk = ~clk;

  spi_out_sched #(.BITS(8), .NREQ(2), .GAP(3)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req(req0), .req_data(data0),
    .ack(ack0), .done(done0), .spi_cs(cs0), .spi_start(start0),
    .spi_data(sdata0), .busy(busy0), .grant_id(gid0)
  );

  spi_out_sched #(.BITS(8), .NREQ(2), .GAP(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req(req1), .req_data(data1),
    .ack(ack1), .done(done1), .spi_cs(cs1), .spi_start(start1),
    .spi_data(sdata1), .busy(busy1), .grant_id(gid1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  // SPI master models: frame starts the edge after start is seen with cs
  // high, then cs stays low for 8 cycles while shifting spi_data MSB first.
  int         bitn0, bitn1;
  logic [7:0] rx0, rx1;
  logic       frame_rdy0, frame_rdy1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs0 <= 1'b1; bitn0 <= 0; rx0 <= '0; frame_rdy0 <= 1'b0;
    end else begin
      frame_rdy0 <= 1'b0;
      if (cs0 && start0) begin
        cs0 <= 1'b0; bitn0 <= 0;
      end else if (!cs0) begin
        rx0   <= {rx0[6:0], sdata0[7-bitn0]};
        bitn0 <= bitn0 + 1;
        if (bitn0 == 7) begin
          cs0 <= 1'b1; frame_rdy0 <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs1 <= 1'b1; bitn1 <= 0; rx1 <= '0; frame_rdy1 <= 1'b0;
    end else begin
      frame_rdy1 <= 1'b0;
      if (cs1 && start1) begin
        cs1 <= 1'b0; bitn1 <= 0;
      end else if (!cs1) begin
        rx1   <= {rx1[6:0], sdata1[7-bitn1]};
        bitn1 <= bitn1 + 1;
        if (bitn1 == 7) begin
          cs1 <= 1'b1; frame_rdy1 <= 1'b1;
        end
      end
    end
  end

  // Monitor: samples on the falling edge.
  int   cyc = 0;
  int   st_len = 0;
  bit   done_due = 0;
  int   done_exp = 0;
  bit   gap_meas_en = 0;
  bit   t_done_valid = 0;
  int   t_done = 0;
  bit   prev_start0 = 0, prev_start1 = 0;
  bit   t_done1_valid = 0;
  int   t_done1 = 0;
  int   frames1 = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset_n) begin
      st_len = 0; done_due = 0; t_done_valid = 0; t_done1_valid = 0;
      prev_start0 = 0; prev_start1 = 0;
    end else begin
      if (ack0 != 0) begin
        if (ack_q.size() == 0) begin
          check("ack_unexpected", int'(ack0), 0);
        end else begin
          e = ack_q.pop_front();
          check("ack", int'(ack0), 1 << e.id);
          check("grant_id", int'(gid0), e.id);
          check("spi_data", int'(sdata0), e.word);
          frm_q.push_back(e);
        end
      end
      if (done_due) begin
        check("done", int'(done0), done_exp);
        done_due = 0;
      end else if (done0 != 0) begin
        check("done_unexpected", int'(done0), 0);
      end
      if (frame_rdy0) begin
        if (frm_q.size() == 0) begin
          check("frame_unexpected", int'(rx0), -1);
        end else begin
          e = frm_q.pop_front();
          check("frame", int'(rx0), e.word);
          done_due = 1;
          done_exp = 1 << e.id;
        end
      end
      if (start0) begin
        st_len++;
      end else if (st_len != 0) begin
        check("start_len", st_len, 2);
        st_len = 0;
      end
      if (!gap_meas_en) begin
        t_done_valid = 0;
      end else begin
        if (start0 && !prev_start0 && t_done_valid) begin
          check("gap3_spacing", cyc - t_done, 4);
          t_done_valid = 0;
        end
        if (done0 != 0) begin
          t_done = cyc; t_done_valid = 1;
        end
      end
      prev_start0 = start0;

      if (start1 && !prev_start1 && t_done1_valid) begin
        check("gap0_spacing", cyc - t_done1, 1);
        t_done1_valid = 0;
      end
      if (done1 != 0) begin
        t_done1 = cyc; t_done1_valid = 1;
      end
      if (frame_rdy1) begin
        check("frame1", int'(rx1), 'h96);
        frames1++;
      end
      prev_start1 = start1;
    end
  end

  task automatic wait_ack0();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (ack0 != 0) return;
    end
    check("timeout_ack", 0, 1);
  endtask

  task automatic wait_done0();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done0 != 0) return;
    end
    check("timeout_done", 0, 1);
  endtask

  // Instance 1: one requester held high for four back-to-back frames.
  initial begin
    int acks;
    acks = 0;
    @(posedge reset_n);
    @(posedge clk); #1;
    req1 = 2'b01;
    for (int i = 0; i < 300 && acks < 4; i++) begin
      @(posedge clk); #1;
      if (ack1 != 0) acks++;
    end
    req1 = 2'b00;
  end

  initial begin
    exp_t e;
    int acks, dones;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", int'(ack0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_start", int'(start0), 0);
    check("rst_data", int'(sdata0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_gid", int'(gid0), 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // single request, data changed right after ack
    data0 = 16'h00A5;
    e.id = 0; e.word = 'hA5; ack_q.push_back(e);
    req0 = 2'b01;
    wait_ack0();
    req0 = 2'b00;
    data0 = 16'h0000;
    wait_done0();
    check("hold_data", int'(sdata0), 'hA5);
    check("hold_gid", int'(gid0), 0);
    repeat (6) @(posedge clk);
    #1;
    check("idle_busy", int'(busy0), 0);

    // round-robin with both held; last grant was 0 so 1 goes first
    data0 = 16'h2211;
    for (int k = 0; k < 4; k++) begin
      e.id = (k % 2 == 0) ? 1 : 0;
      e.word = (e.id == 1) ? 'h22 : 'h11;
      ack_q.push_back(e);
    end
    req0 = 2'b11;
    gap_meas_en = 1;
    acks = 0; dones = 0;
    for (int i = 0; i < 400 && dones < 4; i++) begin
      @(posedge clk); #1;
      if (ack0 != 0) begin
        acks++;
        if (acks == 4) begin
          req0 = 2'b00;
          gap_meas_en = 0;
        end
      end
      if (done0 != 0) dones++;
    end
    check("rr_dones", dones, 4);

    // withdrawn request raised and dropped inside GAP
    req0 = 2'b10;
    @(posedge clk); #1;
    req0 = 2'b00;
    repeat (10) @(posedge clk);
    #1;
    check("withdrawn_busy", int'(busy0), 0);
    check("withdrawn_ackq", ack_q.size(), 0);

    // reset during bit 3 of a frame
    data0 = 16'h3C5A;
    e.id = 0; e.word = 'h5A; ack_q.push_back(e);
    req0 = 2'b01;
    wait_ack0();
    req0 = 2'b00;
    for (int i = 0; i < 50 && !(bitn0 == 3 && !cs0); i++) begin
      @(posedge clk); #1;
    end
    check("reached_bit3", int'(bitn0 == 3 && !cs0), 1);
    reset_n = 1'b0;
    #1;
    check("mrst_ack", int'(ack0), 0);
    check("mrst_done", int'(done0), 0);
    check("mrst_start", int'(start0), 0);
    check("mrst_data", int'(sdata0), 0);
    check("mrst_busy", int'(busy0), 0);
    check("mrst_gid", int'(gid0), 1);
    ack_q.delete();
    frm_q.delete();
    req0 = 2'b10;
    e.id = 1; e.word = 'h3C; ack_q.push_back(e);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_ack0();
    req0 = 2'b00;
    wait_done0();
    repeat (6) @(posedge clk);
    #1;

    check("end_busy", int'(busy0), 0);
    check("end_ackq", ack_q.size(), 0);
    check("end_frmq", frm_q.size(), 0);
    check("frames1", frames1, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
